// File: rtl/fifo_pkg.sv
// Shared types, default thresholds and pointer-width helper for the
// parametrised FIFO and anything that consumes its status.
package fifo_pkg;

    localparam int DEF_AE_LEVEL  = 2;
    localparam int DEF_AF_MARGIN = 2;

    // Pointers carry one extra wrap bit above the index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic is_empty;
        logic is_full;
        logic almost_full;
        logic almost_empty;
        logic overflowed;
        logic underflowed;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, combinational indexed read.
module fifo_mem #(
    parameter int N_BIT = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [N_BIT-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [N_BIT-1:0] rd_data
);

    logic [N_BIT-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and selectable registered or FWFT output.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int N_BIT    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [N_BIT-1:0]       data_in,
    input  logic                   read_val,
    input  logic                   clr_flags,
    output logic [N_BIT-1:0]       data_out,
    output logic                   valid_out,
    output logic                   is_empty,
    output logic                   is_full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflowed,
    output logic                   underflowed
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two and at least 4");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("param_fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [N_BIT-1:0] rd_data;

    assign is_empty     = (count == '0);
    assign is_full      = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    assign rd_ok = read_val & ~is_empty;
    assign wr_ok = en & (~is_full | rd_ok);

    fifo_mem #(
        .N_BIT (N_BIT),
        .DEPTH (DEPTH),
        .IDX_W (IW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_idx  (wr_ptr[IW-1:0]),
        .wr_data (data_in),
        .rd_idx  (rd_ptr[IW-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflowed  <= 1'b0;
            underflowed <= 1'b0;
        end else begin
            if (en & ~wr_ok) begin
                overflowed <= 1'b1;
            end else if (clr_flags) begin
                overflowed <= 1'b0;
            end
            if (read_val & is_empty) begin
                underflowed <= 1'b1;
            end else if (clr_flags) begin
                underflowed <= 1'b0;
            end
        end
    end

    if (FWFT == 0) begin : g_registered
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_out  <= '0;
                valid_out <= 1'b0;
            end else begin
                valid_out <= rd_ok;
                if (rd_ok) begin
                    data_out <= rd_data;
                end
            end
        end
    end else begin : g_fwft
        // Masked while empty so stale, unreset memory never reaches the port.
        assign data_out  = is_empty ? '0 : rd_data;
        assign valid_out = ~is_empty;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: table-driven checks of the registered-read
// variant plus hand-written FWFT and asynchronous-reset sequences.
module tb_param_fifo;

    localparam int NB  = 8;
    localparam int DP  = 8;
    localparam int AFL = 6;
    localparam int AEL = 1;

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [3:0] cnt;
        logic [7:0] dout;
        logic       v;
        logic       ovf;
        logic       udf;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic [NB-1:0] data_in;
    logic read_val;
    logic clr_flags;

    logic [NB-1:0] dout0, dout1;
    logic vout0, vout1, empty0, empty1, full0, full1;
    logic af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
    logic [3:0] count0, count1;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    param_fifo #(.N_BIT(NB), .DEPTH(DP), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .data_in(data_in),
        .read_val(read_val), .clr_flags(clr_flags),
        .data_out(dout0), .valid_out(vout0), .is_empty(empty0), .is_full(full0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflowed(ovf0), .underflowed(udf0)
    );

    param_fifo #(.N_BIT(NB), .DEPTH(DP), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .data_in(data_in),
        .read_val(read_val), .clr_flags(clr_flags),
        .data_out(dout1), .valid_out(vout1), .is_empty(empty1), .is_full(full1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflowed(ovf1), .underflowed(udf1)
    );

    // Status flags follow directly from the occupancy and the thresholds.
    function automatic logic [18:0] exp_pack(input logic [3:0] c, input logic [7:0] d,
                                             input logic v, input logic o, input logic u);
        return {c, d, v, (c == 4'd0), (c == 4'd8), (c >= 4'd6), (c <= 4'd1), o, u};
    endfunction

    function automatic logic [18:0] act0();
        return {count0, dout0, vout0, empty0, full0, af0, ae0, ovf0, udf0};
    endfunction

    function automatic logic [18:0] act1();
        return {count1, dout1, vout1, empty1, full1, af1, ae1, ovf1, udf1};
    endfunction

    function automatic void add(input logic e, input int d, input logic r, input logic c,
                                input int cnt, input int dout, input logic v,
                                input logic o, input logic u);
        vec_t t;
        t.en = e; t.din = 8'(d); t.rd = r; t.clr = c;
        t.cnt = 4'(cnt); t.dout = 8'(dout); t.v = v; t.ovf = o; t.udf = u;
        vecs.push_back(t);
    endfunction

    task automatic check_output(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got cnt=%0d dout=%0d v=%b e/f/af/ae=%b ovf/udf=%b, wanted cnt=%0d dout=%0d v=%b e/f/af/ae=%b ovf/udf=%b",
                     name, act[18:15], act[14:7], act[6], act[5:2], act[1:0],
                     exp[18:15], exp[14:7], exp[6], exp[5:2], exp[1:0]);
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic [7:0] d, input logic r, input logic c);
        en = e; data_in = d; read_val = r; clr_flags = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; data_in = '0; read_val = 1'b0; clr_flags = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        // Order, registered read
        add(1, 21, 0, 0, 1, 0, 0, 0, 0);
        add(1, 23, 0, 0, 2, 0, 0, 0, 0);
        add(1, 28, 0, 0, 3, 0, 0, 0, 0);
        add(1, 27, 0, 0, 4, 0, 0, 0, 0);
        add(1, 26, 0, 0, 5, 0, 0, 0, 0);
        add(0, 0, 1, 0, 4, 21, 1, 0, 0);
        add(0, 0, 1, 0, 3, 23, 1, 0, 0);
        add(0, 0, 1, 0, 2, 28, 1, 0, 0);
        add(0, 0, 1, 0, 1, 27, 1, 0, 0);
        add(0, 0, 1, 0, 0, 26, 1, 0, 0);
        add(0, 0, 0, 0, 0, 26, 0, 0, 0);
        // Full and overflow
        for (int i = 1; i <= 8; i++) add(1, i, 0, 0, i, 26, 0, 0, 0);
        add(1, 9, 0, 0, 8, 26, 0, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 8 - i, i, 1, 1, 0);
        add(0, 0, 0, 1, 0, 8, 0, 0, 0);
        // Simultaneous read/write at full, then drain across the wrap
        for (int i = 1; i <= 8; i++) add(1, i, 0, 0, i, 8, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(1, 30 + k, 1, 0, 8, 1 + k, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 7 - i, 5 + i, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 3 - i, 30 + i, 1, 0, 0);
        // Underflow and clear priority
        add(0, 0, 1, 0, 0, 33, 0, 0, 1);
        add(0, 0, 1, 1, 0, 33, 0, 0, 1);
        add(0, 0, 0, 1, 0, 33, 0, 0, 0);
        // Write into empty with same-cycle read: no bypass, counts as underflow
        add(1, 77, 1, 0, 1, 33, 0, 0, 1);
        add(0, 0, 0, 1, 1, 33, 0, 0, 0);
        add(0, 0, 1, 0, 0, 77, 1, 0, 0);

        do_reset();
        check_output("reset_fwft0", act0(), exp_pack(0, 0, 0, 0, 0));
        check_output("reset_fwft1", act1(), exp_pack(0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].en, vecs[i].din, vecs[i].rd, vecs[i].clr);
            check_output($sformatf("vec%0d", i), act0(),
                         exp_pack(vecs[i].cnt, vecs[i].dout, vecs[i].v, vecs[i].ovf, vecs[i].udf));
        end

        // FWFT sequence
        do_reset();
        apply_stimulus(1, 8'd40, 0, 0);
        check_output("fwft_first", act1(), exp_pack(1, 40, 1, 0, 0));
        apply_stimulus(1, 8'd41, 0, 0);
        check_output("fwft_second", act1(), exp_pack(2, 40, 1, 0, 0));
        apply_stimulus(0, 8'd0, 1, 0);
        check_output("fwft_pop", act1(), exp_pack(1, 41, 1, 0, 0));
        apply_stimulus(1, 8'd42, 0, 0);
        check_output("fwft_burst", act1(), exp_pack(2, 41, 1, 0, 0));

        // Asynchronous reset between clock edges, mid-burst
        en = 1'b1; data_in = 8'd43;
        #3 reset_n = 1'b0;
        #1;
        check_output("async_rst_fwft1", act1(), exp_pack(0, 0, 0, 0, 0));
        check_output("async_rst_fwft0", act0(), exp_pack(0, 0, 0, 0, 0));
        en = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        apply_stimulus(0, 8'd0, 0, 0);
        check_output("post_rst_idle", act1(), exp_pack(0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised synchronous FIFO that succeeds the fixed 8-bit buffer in the OFDM datapath buffer stage. Width, depth and almost-full/almost-empty thresholds are configurable. It reports an occupancy count and sticky overflow/underflow flags with a clear input. A mode parameter selects either registered-read output or first-word-fall-through (FWFT) output. The block sits between symbol producers (mapper, IFFT output) and consumers that stall.

## Interface
- N_BIT, 8, data word width (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  write request
- data_in  in  N_BIT  write data, sampled when en=1
- read_val  in  1  read request / pop
- clr_flags  in  1  synchronous clear of the sticky flags
- data_out  out  N_BIT  read data
- valid_out  out  1  data_out holds a popped word (FWFT=0) or the head word (FWFT=1)
- is_empty  out  1  count == 0
- is_full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflowed  out  1  sticky: a write was dropped
- underflowed  out  1  sticky: a read hit an empty FIFO

## Operation
- Storage: DEPTH×N_BIT array, write pointer and read pointer each $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit. The index is the low bits, and it wraps DEPTH-1 → 0 naturally.
- rd_ok = read_val & !is_empty.
- wr_ok = en & (!is_full | rd_ok). A write into a full FIFO is accepted if a pop happens in the same cycle.
- On a write to an empty FIFO, the word is not bypassed to a same-cycle read; the read is an underflow.
- count next = count + wr_ok − rd_ok. Simultaneous accepted read and write leave count unchanged.
- The status outputs is_empty, is_full, almost_full and almost_empty are decoded from the registered count.
- overflowed is set by en & !wr_ok. underflowed is set by read_val & is_empty. A dropped write does not change memory or pointers.
- clr_flags clears both sticky flags next cycle. If a set event occurs in the same cycle, the set wins.
- FWFT=0: on rd_ok, data_out is loaded with mem[rd_idx] and valid_out=1 for one cycle. Otherwise valid_out=0 and data_out holds its last value.
- FWFT=1: data_out = mem[rd_idx] and valid_out = !is_empty. read_val acts as a pop/acknowledge.
- Reset (asynchronous, any time including mid-burst) sets:
  - pointers = 0, count = 0
  - is_empty = 1, is_full = 0, almost_empty = 1, almost_full = 0
  - overflowed = 0, underflowed = 0
  - data_out = 0, valid_out = 0
- Memory contents are not reset.

## Timing
- Write: data is visible to the read side in the cycle after the accepting edge. In FWFT=1, data_out and valid_out update one cycle after the write to an empty FIFO.
- Read, FWFT=0: data_out and valid_out appear one cycle after the edge that sampled read_val.
- Read, FWFT=1: zero latency. The next word is presented the cycle after a pop.
- Status outputs and count update one cycle after the request edge.
- Back-to-back reads and writes sustain one word per clock.

## Structure
- Package fifo_pkg holds:
  - function ptr_w(DEPTH) = $clog2(DEPTH)+1
  - localparams for default thresholds
  - packed struct fifo_status_t {is_empty, is_full, almost_full, almost_empty, overflowed, underflowed}, for downstream status buses
- One sub-module, fifo_mem: a simple dual-port array with a synchronous write port and an asynchronous-index read port. The top level adds the registered output for FWFT=0.
- Elaboration assertions:
  - DEPTH is a power of two
  - AE_LEVEL < AF_LEVEL ≤ DEPTH

## Test plan
All scenarios use N_BIT=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1 unless stated.
- Reset/idle: hold reset_n=0 for 3 cycles, then release → count=0, is_empty=1, almost_empty=1, flags=0, data_out=0, valid_out=0.
- Order, FWFT=0: write 21,23,28,27,26, then read 5 → data_out 21,23,28,27,26, each one cycle after its read_val. almost_empty toggles at count 1→2, and is_empty=1 at the end.
- Full and overflow: write 9 words 1..9 → is_full=1, almost_full=1 from count=6, and overflowed=1 after word 9. Read back 8 words → 1..8, and 9 is absent.
- Simultaneous: fill to 8, then en=1 and read_val=1 for 4 cycles with 30..33 → count stays 8 and overflowed stays 0. Draining yields 5..8,30..33 (pointer wrap checked).
- Underflow/clear: read_val=1 while empty → underflowed=1. Assert clr_flags in the same cycle as another empty read → flag stays 1. clr_flags alone → 0 next cycle.
- FWFT=1 and mid-operation reset: write 40,41 → data_out=40 with valid_out=1 the cycle after the first write. Pop → 41. Pulse reset_n=0 mid-burst → all outputs at reset values immediately (asynchronous), count=0.
